// File: rtl/hcsr04_ctrl_if.sv
// HC-SR04 controller pin bundle: start pulse and echo in, trigger and result strobe out.
// The controller binds the slave modport; the start source/sensor side binds master.
interface hcsr04_ctrl_if;
   logic       i_start;
   logic       echo;
   logic       o_trig;
   logic [8:0] o_dist;
   logic       o_valid;
   logic       o_err;
   logic       o_busy;

   modport master (
      output i_start, echo,
      input  o_trig, o_dist, o_valid, o_err, o_busy
   );

   modport slave (
      input  i_start, echo,
      output o_trig, o_dist, o_valid, o_err, o_busy
   );
endinterface

// File: rtl/hcsr04_ctrl.sv
// HC-SR04 ranging FSM: 1 us prescaled trigger/echo timing, echo width -> cm by counting, no divider.
// Define HCSR04_AUTO_EN for free-running repeats after the first start; o_valid pulses once per measurement.
module hcsr04_ctrl #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TRIG_US     = 10,
   parameter int US_PER_CM   = 58,
   parameter int TIMEOUT_US  = 30_000,
   parameter int COOLDOWN_US = 60_000
) (
   input  logic         clk,
   input  logic         rst,
   hcsr04_ctrl_if.slave bus
);
   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int MAX_A  = (TIMEOUT_US > COOLDOWN_US) ? TIMEOUT_US : COOLDOWN_US;
   localparam int MAX_US = (MAX_A > TRIG_US) ? MAX_A : TRIG_US;
   localparam int US_W   = $clog2(MAX_US + 1);
   localparam int PRE_W  = $clog2(DIV);
   localparam int SUB_W  = $clog2(US_PER_CM + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_TRIG     = 3'd1;
   localparam logic [2:0] S_WAIT     = 3'd2;
   localparam logic [2:0] S_MEASURE  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_COOLDOWN = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [US_W-1:0]  us_q, us_d;
   logic [SUB_W-1:0] sub_q, sub_d;
   logic [8:0]       cm_q, cm_d;
   logic [8:0]       dist_q, dist_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             echo_s1_q, echo_s2_q, echo_d1_q;
   logic             tick, echo_rise, echo_fall;

   assign tick      = (pre_q == PRE_W'(DIV - 1));
   assign echo_rise = echo_s2_q & ~echo_d1_q;
   assign echo_fall = ~echo_s2_q & echo_d1_q;

   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + 1'b1;
      us_d    = tick ? us_q + 1'b1 : us_q;
      sub_d   = sub_q;
      cm_d    = cm_q;
      dist_d  = dist_q;
      err_d   = err_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) state_d = S_TRIG;
         end
         S_TRIG: begin
            if (tick && us_q == US_W'(TRIG_US - 1)) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (echo_rise) begin
               state_d = S_MEASURE;
               sub_d   = '0;
               cm_d    = '0;
            end else if (tick && us_q == US_W'(TIMEOUT_US - 1)) begin
               state_d = S_COOLDOWN;
               err_d   = 1'b1;
               valid_d = 1'b1;
            end
         end
         S_MEASURE: begin
            // a tick landing on the fall-detect cycle still counts toward the width
            if (tick) begin
               if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                  sub_d = '0;
                  if (cm_q != 9'd511) cm_d = cm_q + 1'b1;
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
            if (echo_fall) begin
               state_d = S_DONE;
            end else if (tick && us_q == US_W'(TIMEOUT_US - 1)) begin
               state_d = S_COOLDOWN;
               err_d   = 1'b1;
               valid_d = 1'b1;
            end
         end
         S_DONE: begin
            dist_d  = cm_q;
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = S_COOLDOWN;
         end
         S_COOLDOWN: begin
            if (tick && us_q == US_W'(COOLDOWN_US - 1)) begin
`ifdef HCSR04_AUTO_EN
               state_d = S_TRIG;
`else
               state_d = S_IDLE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      // every state starts timing from a fresh microsecond boundary
      if (state_d != state_q) begin
         pre_d = '0;
         us_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         us_q      <= '0;
         sub_q     <= '0;
         cm_q      <= '0;
         dist_q    <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         echo_s1_q <= 1'b0;
         echo_s2_q <= 1'b0;
         echo_d1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         us_q      <= us_d;
         sub_q     <= sub_d;
         cm_q      <= cm_d;
         dist_q    <= dist_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         echo_s1_q <= bus.echo;
         echo_s2_q <= echo_s1_q;
         echo_d1_q <= echo_s2_q;
      end
   end

   assign bus.o_trig  = (state_q == S_TRIG);
   assign bus.o_busy  = (state_q != S_IDLE);
   assign bus.o_dist  = dist_q;
   assign bus.o_err   = err_q;
   assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_hcsr04_ctrl.sv
// Directed + randomized bench for hcsr04_ctrl at a scaled clock (2 cycles/us) and short timeouts.
module tb_hcsr04_ctrl;
   localparam int CLK_HZ      = 2_000_000;
   localparam int DIV         = 2;
   localparam int TRIG_US     = 10;
   localparam int US_PER_CM   = 4;
   localparam int TIMEOUT_US  = 2500;
   localparam int COOLDOWN_US = 200;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int   n_valid = 0, n_trig = 0;
   int   trig_rise_cyc = -1, trig_fall_cyc = -1, valid_cyc = -1, busy_fall_cyc = -1;
   logic trig_prev = 1'b0, busy_prev = 1'b0;
   logic [8:0] model_dist;

   hcsr04_ctrl_if bus ();

   hcsr04_ctrl #(
      .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .US_PER_CM(US_PER_CM),
      .TIMEOUT_US(TIMEOUT_US), .COOLDOWN_US(COOLDOWN_US)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         n_valid++;
         valid_cyc = cyc;
      end
      if (bus.o_trig === 1'b1 && trig_prev !== 1'b1) begin
         n_trig++;
         trig_rise_cyc = cyc;
      end
      if (bus.o_trig === 1'b0 && trig_prev === 1'b1) trig_fall_cyc = cyc;
      if (bus.o_busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc;
      trig_prev = bus.o_trig;
      busy_prev = bus.o_busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      step(1);
      bus.i_start = 1'b0;
   endtask

   // Reference: whole cm = floor(width / us_per_cm) capped at 511; no echo or overlong echo is an error.
   task automatic run_meas(input string tag, input bit pre_high, input int delay_us,
                           input int width_us, input bit spam);
      int n0, t0, lim, half;
      bit want_err;
      logic [8:0] want_dist;
      n0 = n_valid;
      t0 = n_trig;
      if (width_us == 0 || width_us >= TIMEOUT_US) begin
         want_err  = 1'b1;
         want_dist = model_dist;
      end else begin
         want_err  = 1'b0;
         want_dist = (width_us / US_PER_CM > 511) ? 9'd511 : 9'(width_us / US_PER_CM);
      end
      bus.echo = pre_high;
      pulse_start();
      check({tag, ".trig_on"}, bus.o_trig, 1);
      check({tag, ".busy_on"}, bus.o_busy, 1);
      if (spam) begin
         step(5);
         pulse_start();
      end
      lim = 0;
      while (bus.o_trig === 1'b1 && lim < 200) begin
         step(1);
         lim++;
      end
      step(1);
      check({tag, ".trig_width"}, trig_fall_cyc - trig_rise_cyc, TRIG_US * DIV);
      if (pre_high) begin
         step(30 * DIV);
         bus.echo = 1'b0;
      end
      step(delay_us * DIV);
      if (width_us > 0) begin
         bus.echo = 1'b1;
         half = width_us * DIV / 2;
         if (spam) begin
            step(half);
            pulse_start();
            step(width_us * DIV - half - 1);
         end else begin
            step(width_us * DIV);
         end
         bus.echo = 1'b0;
      end
      lim = 0;
      while (n_valid == n0 && lim < (TIMEOUT_US + 100) * DIV) begin
         step(1);
         lim++;
      end
      check({tag, ".valid_seen"}, n_valid - n0, 1);
      check({tag, ".err"}, bus.o_err, want_err);
      check({tag, ".dist"}, bus.o_dist, want_dist);
      if (width_us == 0)
         check({tag, ".timeout_latency"}, valid_cyc - trig_fall_cyc, TIMEOUT_US * DIV);
      if (spam) begin
         step(20);
         pulse_start();
      end
      lim = 0;
      while (bus.o_busy === 1'b1 && lim < (COOLDOWN_US + 50) * DIV) begin
         step(1);
         lim++;
      end
      step(20);
      check({tag, ".cooldown"}, busy_fall_cyc - valid_cyc, COOLDOWN_US * DIV);
      check({tag, ".one_valid"}, n_valid - n0, 1);
      check({tag, ".one_trig"}, n_trig - t0, 1);
      check({tag, ".idle"}, bus.o_busy, 0);
      if (!want_err) model_dist = want_dist;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n0;
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.echo    = 1'b0;
      model_dist  = '0;
      step(3);
      check("rst.trig", bus.o_trig, 0);
      check("rst.dist", bus.o_dist, 0);
      check("rst.valid", bus.o_valid, 0);
      check("rst.err", bus.o_err, 0);
      check("rst.busy", bus.o_busy, 0);
      rst = 1'b0;
      step(5);

      run_meas("nominal", 1'b0, 50, 42, 1'b0);
      run_meas("saturate", 1'b0, 20, 2100, 1'b0);
      run_meas("truncate", 1'b0, 30, 43, 1'b0);
      run_meas("no_echo", 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         w = 4 * int'($urandom_range(5, 250)) + 1 + int'($urandom_range(0, 1));
         run_meas("random", 1'b0, int'($urandom_range(1, 60)), w, 1'b0);
      end
      run_meas("stuck_high", 1'b0, 15, TIMEOUT_US + 20, 1'b0);
      run_meas("pre_high", 1'b1, 25, 200, 1'b0);
      run_meas("ignored_starts", 1'b0, 40, 121, 1'b1);

      // abort mid-measurement
      n0 = n_valid;
      bus.echo = 1'b0;
      pulse_start();
      step(TRIG_US * DIV + 20 * DIV);
      bus.echo = 1'b1;
      step(100 * DIV);
      rst = 1'b1;
      step(1);
      check("midrst.trig", bus.o_trig, 0);
      check("midrst.dist", bus.o_dist, 0);
      check("midrst.valid", bus.o_valid, 0);
      check("midrst.err", bus.o_err, 0);
      check("midrst.busy", bus.o_busy, 0);
      rst = 1'b0;
      step(50);
      bus.echo = 1'b0;
      step(600);
      check("midrst.no_valid", n_valid - n0, 0);
      check("midrst.idle", bus.o_busy, 0);
      model_dist = '0;

      w = 4 * int'($urandom_range(5, 250)) + 1 + int'($urandom_range(0, 1));
      run_meas("after_reset", 1'b0, int'($urandom_range(1, 60)), w, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
